// File: rtl/box_pkg.sv
// Shared types and helpers for the box-overlay front end.
package box_pkg;

  localparam int DEF_H_ACT = 1280;
  localparam int DEF_V_ACT = 720;
  localparam int HW        = $clog2(DEF_H_ACT);
  localparam int VW        = $clog2(DEF_V_ACT);
  localparam int COLOR_W   = 24;

  // One box entry at the default geometry. The top re-declares the same
  // layout at its own parameter widths so smaller rasters stay exact.
  typedef struct packed {
    logic [HW-1:0]      sx;
    logic [VW-1:0]      sy;
    logic [HW-1:0]      ex;
    logic [VW-1:0]      ey;
    logic [COLOR_W-1:0] color;
  } box_t;

  // Saturate a column coordinate to the last active pixel.
  function automatic int unsigned clamp_h(input int unsigned v, input int unsigned h_act);
    return (v >= h_act) ? h_act - 1 : v;
  endfunction

  // Saturate a row coordinate to the last active line.
  function automatic int unsigned clamp_v(input int unsigned v, input int unsigned v_act);
    return (v >= v_act) ? v_act - 1 : v;
  endfunction

endpackage

// File: rtl/box_frame_buffer_pixel_coord_gen.sv
// Pixel coordinate counters derived from vsync/de, plus the vsync rising-edge pulse.
module pixel_coord_gen #(
  parameter int  H_ACT = 1280,
  parameter int  V_ACT = 720,
  localparam int XW    = $clog2(H_ACT),
  localparam int YW    = $clog2(V_ACT)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          vsync,
  input  logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          vsync_rise
);

  logic vsync_d;
  logic de_d;
  logic de_fall;

  assign vsync_rise = vsync & ~vsync_d;
  assign de_fall    = de_d & ~de;

  // Edge-detect registers and saturating x/y counters; vsync rise wins over line advance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync_d <= 1'b0;
      de_d    <= 1'b0;
      x       <= '0;
      y       <= '0;
    end else begin
      vsync_d <= vsync;
      de_d    <= de;
      if (de_fall)
        x <= '0;
      else if (de && x != XW'(H_ACT - 1))
        x <= x + XW'(1);
      if (vsync_rise)
        y <= '0;
      else if (de_fall && y != YW'(V_ACT - 1))
        y <= y + YW'(1);
    end
  end

endmodule

// File: rtl/box_frame_buffer.sv
// Double-buffered box table: batches fill the back bank, vsync swaps it to the front.
module box_frame_buffer
  import box_pkg::*;
#(
  parameter int  N_BOX          = 4,
  parameter int  V_ACT          = DEF_V_ACT,
  parameter int  H_ACT          = DEF_H_ACT,
  parameter int  TIMEOUT_FRAMES = 8,
  localparam int XW             = $clog2(H_ACT),
  localparam int YW             = $clog2(V_ACT),
  localparam int IW             = (N_BOX > 1) ? $clog2(N_BOX) : 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       vsync,
  input  logic                       de,
  output logic [XW-1:0]              x,
  output logic [YW-1:0]              y,
  input  logic                       box_valid,
  output logic                       box_ready,
  input  logic [IW-1:0]              box_idx,
  input  logic [XW-1:0]              box_sx,
  input  logic [YW-1:0]              box_sy,
  input  logic [XW-1:0]              box_ex,
  input  logic [YW-1:0]              box_ey,
  input  logic [COLOR_W-1:0]         box_color,
  input  logic                       box_last,
  output logic [N_BOX*XW-1:0]        start_xs,
  output logic [N_BOX*YW-1:0]        start_ys,
  output logic [N_BOX*XW-1:0]        end_xs,
  output logic [N_BOX*YW-1:0]        end_ys,
  output logic [N_BOX*COLOR_W-1:0]   colors,
  output logic                       swap
);

  localparam int TW = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;

  typedef struct packed {
    logic [XW-1:0]      sx;
    logic [YW-1:0]      sy;
    logic [XW-1:0]      ex;
    logic [YW-1:0]      ey;
    logic [COLOR_W-1:0] color;
  } slot_t;

  slot_t          back  [N_BOX];
  slot_t          front [N_BOX];
  slot_t          wr;
  logic           pending;
  logic [TW-1:0]  tcnt;
  logic           vsync_rise;
  logic           accept;
  logic           timeout_hit;

  pixel_coord_gen #(.H_ACT(H_ACT), .V_ACT(V_ACT)) u_coord (
    .clk        (clk),
    .rstn       (rstn),
    .vsync      (vsync),
    .de         (de),
    .x          (x),
    .y          (y),
    .vsync_rise (vsync_rise)
  );

  // Edge cycles are reserved for swap/clear, so a commit can never race a vsync.
  assign box_ready   = rstn & ~pending & ~vsync_rise;
  assign accept      = box_valid & box_ready;
  assign timeout_hit = (TIMEOUT_FRAMES > 0) && (int'(tcnt) + 1 == TIMEOUT_FRAMES);

  // Clamp incoming coordinates to the active raster.
  always_comb begin
    wr.sx    = XW'(clamp_h(32'(box_sx), H_ACT));
    wr.sy    = YW'(clamp_v(32'(box_sy), V_ACT));
    wr.ex    = XW'(clamp_h(32'(box_ex), H_ACT));
    wr.ey    = YW'(clamp_v(32'(box_ey), V_ACT));
    wr.color = box_color;
  end

  // Bank swap on vsync with a committed batch, stale-front clear on timeout, back-bank writes otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_BOX; i++) begin
        back[i]  <= '0;
        front[i] <= '0;
      end
      pending <= 1'b0;
      tcnt    <= '0;
      swap    <= 1'b0;
    end else begin
      swap <= 1'b0;
      if (vsync_rise) begin
        if (pending) begin
          for (int i = 0; i < N_BOX; i++) begin
            front[i] <= back[i];
            back[i]  <= '0;
          end
          pending <= 1'b0;
          tcnt    <= '0;
          swap    <= 1'b1;
        end else if (TIMEOUT_FRAMES > 0) begin
          if (timeout_hit) begin
            for (int i = 0; i < N_BOX; i++) front[i] <= '0;
            tcnt <= '0;
            swap <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
      end else if (accept) begin
        // Out-of-range slots are acknowledged but discarded.
        if (int'(box_idx) < N_BOX) back[box_idx] <= wr;
        if (box_last) pending <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_BOX; i++) begin : g_out
    assign start_xs[i*XW +: XW]           = front[i].sx;
    assign start_ys[i*YW +: YW]           = front[i].sy;
    assign end_xs[i*XW +: XW]             = front[i].ex;
    assign end_ys[i*YW +: YW]             = front[i].ey;
    assign colors[i*COLOR_W +: COLOR_W]   = front[i].color;
  end

endmodule
